// File: rtl/ped_xing_pkg.sv
// Shared types for the pedestrian crossing controller: FSM states and lamp vector.
package ped_xing_pkg;

  typedef enum logic [2:0] {
    CAR_GO,
    CAR_YELLOW,
    ALL_RED1,
    PED_WALK,
    PED_FLASH,
    ALL_RED2
  } state_t;

  typedef struct packed {
    logic car_green;
    logic car_yellow;
    logic car_red;
    logic ped_walk;
    logic ped_dont_walk;
  } lamps_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running tick divider; restart pulls the count back to 0 so each phase
// starts on a fresh tick boundary.
module tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (restart || tick)
      count <= '0;
    else
      count <= count + 1'b1;
  end

endmodule

// File: rtl/ped_xing_ctrl.sv
// Request-driven pedestrian crossing controller with flashing-walk clearance and countdown.
//
// state      | meaning
// CAR_GO     | car green, don't-walk; waits for min-green expiry and a pending request
// CAR_YELLOW | car yellow, don't-walk
// ALL_RED1   | all red before the pedestrian phase
// PED_WALK   | car red, steady walk
// PED_FLASH  | car red, walk flashes with timer[0], countdown shows remaining ticks
// ALL_RED2   | all red after the pedestrian phase
module ped_xing_ctrl
  import ped_xing_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int TICK_DIV  = 1000,
  parameter int MIN_GREEN = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 5,
  parameter int FLASH_T   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ped_req,
  output logic             car_green,
  output logic             car_yellow,
  output logic             car_red,
  output logic             ped_walk,
  output logic             ped_dont_walk,
  output logic [CNT_W-1:0] countdown,
  output logic             req_pending
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             sync1, sync2, sync3;
  logic             req_pending_d;
  logic             tick, restart, req_edge;
  lamps_t           lamps;
  logic [CNT_W-1:0] countdown_c;

  function automatic logic [CNT_W-1:0] dur(input state_t s);
    case (s)
      CAR_GO:             dur = CNT_W'(MIN_GREEN);
      CAR_YELLOW:         dur = CNT_W'(YELLOW_T);
      ALL_RED1, ALL_RED2: dur = CNT_W'(ALLRED_T);
      PED_WALK:           dur = CNT_W'(WALK_T);
      PED_FLASH:          dur = CNT_W'(FLASH_T);
      default:            dur = CNT_W'(MIN_GREEN);
    endcase
  endfunction

  assign restart  = (state_d != state_q);
  assign req_edge = sync2 & ~sync3;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (tick && (timer_q != '0))
      timer_d = timer_q - 1'b1;
    case (state_q)
      CAR_GO:     if ((timer_q == '0) && req_pending) state_d = CAR_YELLOW;
      CAR_YELLOW: if (tick && (timer_q == CNT_W'(1))) state_d = ALL_RED1;
      ALL_RED1:   if (tick && (timer_q == CNT_W'(1))) state_d = PED_WALK;
      PED_WALK:   if (tick && (timer_q == CNT_W'(1))) state_d = PED_FLASH;
      PED_FLASH:  if (tick && (timer_q == CNT_W'(1))) state_d = ALL_RED2;
      ALL_RED2:   if (tick && (timer_q == CNT_W'(1))) state_d = CAR_GO;
      default:    state_d = CAR_GO;
    endcase
    if (state_d != state_q)
      timer_d = dur(state_d);
  end

  // Clearing on entry to PED_WALK outranks a simultaneous new press.
  always_comb begin
    req_pending_d = req_pending;
    if ((state_d == PED_WALK) && (state_q != PED_WALK))
      req_pending_d = 1'b0;
    else if (req_edge && !(state_q inside {PED_WALK, PED_FLASH, ALL_RED2}))
      req_pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CAR_GO;
      timer_q     <= CNT_W'(MIN_GREEN);
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      sync3       <= 1'b0;
      req_pending <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      sync1       <= ped_req;
      sync2       <= sync1;
      sync3       <= sync2;
      req_pending <= req_pending_d;
    end
  end

  always_comb begin
    lamps       = '0;
    countdown_c = '0;
    case (state_q)
      CAR_GO:     begin lamps.car_green  = 1'b1; lamps.ped_dont_walk = 1'b1; end
      CAR_YELLOW: begin lamps.car_yellow = 1'b1; lamps.ped_dont_walk = 1'b1; end
      PED_WALK:   begin lamps.car_red    = 1'b1; lamps.ped_walk      = 1'b1; end
      PED_FLASH: begin
        lamps.car_red  = 1'b1;
        lamps.ped_walk = timer_q[0];
        countdown_c    = timer_q;
      end
      default:    begin lamps.car_red    = 1'b1; lamps.ped_dont_walk = 1'b1; end
    endcase
  end

  assign car_green     = lamps.car_green;
  assign car_yellow    = lamps.car_yellow;
  assign car_red       = lamps.car_red;
  assign ped_walk      = lamps.ped_walk;
  assign ped_dont_walk = lamps.ped_dont_walk;
  assign countdown     = countdown_c;

endmodule

// File: tb/tb_ped_xing_ctrl.sv
// Scoreboard bench for ped_xing_ctrl: directed stimulus queues per-cycle expectations,
// an independent monitor compares them at the falling edge or on an async-check strobe.
module tb_ped_xing_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             ped_req = 1'b0;
  logic             car_green, car_yellow, car_red, ped_walk, ped_dont_walk, req_pending;
  logic [CNT_W-1:0] countdown;
  logic [9:0]       obs;

  ped_xing_ctrl #(
    .CNT_W(4), .TICK_DIV(4), .MIN_GREEN(3), .YELLOW_T(2),
    .ALLRED_T(1), .WALK_T(3), .FLASH_T(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ped_req       (ped_req),
    .car_green     (car_green),
    .car_yellow    (car_yellow),
    .car_red       (car_red),
    .ped_walk      (ped_walk),
    .ped_dont_walk (ped_dont_walk),
    .countdown     (countdown),
    .req_pending   (req_pending)
  );

  always #5 clk = ~clk;

  assign obs = {car_green, car_yellow, car_red, ped_walk, ped_dont_walk, req_pending, countdown};

  // lamp order: green, yellow, red, walk, dont_walk
  localparam logic [4:0] L_GO   = 5'b10001;
  localparam logic [4:0] L_YEL  = 5'b01001;
  localparam logic [4:0] L_RED  = 5'b00101;
  localparam logic [4:0] L_WALK = 5'b00110;
  localparam logic [4:0] L_FL0  = 5'b00100;
  localparam logic [4:0] L_FL1  = 5'b00110;

  typedef struct {
    int         cyc;
    bit         is_async;
    logic [9:0] v;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   base = 0;
  int   span_limit = 1000000;
  int   vectors = 0;
  int   miscompares = 0;
  bit   async_strobe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or posedge async_strobe);
      while (exp_q.size() > 0) begin
        e = exp_q[0];
        if (e.is_async != async_strobe) break;
        if (!e.is_async && (e.cyc > cyc)) break;
        void'(exp_q.pop_front());
        vectors++;
        if (!e.is_async && (e.cyc < cyc)) begin
          $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d", e.name, e.cyc, cyc);
          miscompares++;
        end else if (obs !== e.v) begin
          $display("FAIL %s @edge %0d: got g/y/r/w/dw/rp/cd=%b required %b",
                   e.name, e.cyc - base, obs, e.v);
          miscompares++;
        end
      end
    end
  end

  task automatic span(input int from, input int to, input logic [4:0] l, input bit rp,
                      input int cd, input string nm);
    for (int k = from; k <= to; k++)
      if (k <= span_limit)
        exp_q.push_back('{base + k, 1'b0, {l, rp, 4'(cd)}, nm});
  endtask

  task automatic check_async(input logic [4:0] l, input bit rp, input int cd, input string nm);
    exp_q.push_back('{0, 1'b1, {l, rp, 4'(cd)}, nm});
    #1 async_strobe = 1'b1;
    #1 async_strobe = 1'b0;
  endtask

  task automatic to_edge(input int k);
    while (cyc < base + k) @(negedge clk);
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    reset   = 1'b1;
    ped_req = 1'b0;
    if (check) check_async(L_GO, 1'b0, 0, "reset_hold");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base  = cyc;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_q.size() > 0) && (n < 500)) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      $display("FAIL %s: %0d expectations still pending after cycle budget", nm, exp_q.size());
      miscompares++;
      exp_q.delete();
    end
  endtask

  // Full service cycle with press after edge 20 (timings hand-derived for TICK_DIV=4).
  task automatic push_service(input int green_tail, input string pfx);
    span(1,  22, L_GO,   1'b0, 0, {pfx, "_green"});
    span(23, 23, L_GO,   1'b1, 0, {pfx, "_req_latched"});
    span(24, 31, L_YEL,  1'b1, 0, {pfx, "_yellow"});
    span(32, 35, L_RED,  1'b1, 0, {pfx, "_allred1"});
    span(36, 47, L_WALK, 1'b0, 0, {pfx, "_walk"});
    span(48, 51, L_FL0,  1'b0, 4, {pfx, "_flash4"});
    span(52, 55, L_FL1,  1'b0, 3, {pfx, "_flash3"});
    span(56, 59, L_FL0,  1'b0, 2, {pfx, "_flash2"});
    span(60, 63, L_FL1,  1'b0, 1, {pfx, "_flash1"});
    span(64, 67, L_RED,  1'b0, 0, {pfx, "_allred2"});
    span(68, 67 + green_tail, L_GO, 1'b0, 0, {pfx, "_green_again"});
  endtask

  initial begin : stimulus
    do_reset(1'b1);
    span(1, 200, L_GO, 1'b0, 0, "idle_green");
    drain("idle");

    do_reset(1'b0);
    push_service(33, "svc");
    to_edge(20); ped_req = 1'b1;
    to_edge(26); ped_req = 1'b0;
    drain("svc");

    do_reset(1'b0);
    span(1,  4,  L_GO,   1'b0, 0, "early_green");
    span(5,  12, L_GO,   1'b1, 0, "early_min_green");
    span(13, 20, L_YEL,  1'b1, 0, "early_yellow");
    span(21, 24, L_RED,  1'b1, 0, "early_allred1");
    span(25, 26, L_WALK, 1'b0, 0, "early_walk");
    to_edge(2); ped_req = 1'b1;
    to_edge(3); ped_req = 1'b0;
    drain("early");

    do_reset(1'b0);
    push_service(200, "ign");
    to_edge(20); ped_req = 1'b1;
    to_edge(37); ped_req = 1'b0;
    to_edge(40); ped_req = 1'b1;
    drain("ign");

    do_reset(1'b0);
    span_limit = 53;
    push_service(0, "rst");
    to_edge(20); ped_req = 1'b1;
    to_edge(53);
    #2 reset = 1'b1;
    ped_req = 1'b0;
    check_async(L_GO, 1'b0, 0, "reset_mid_flash");
    @(negedge clk);
    reset = 1'b0;
    drain("rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
